// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. A PicoBlaze write to PORT_TX starts the
// request-to-send sequence: the host holds the clock low, then drives the
// start bit. After that the device supplies the clock while the host shifts
// out 8 data bits, odd parity and stop. The host then checks the device ACK.
// Both PS/2 lines are open-drain: they are only ever driven low or released.
module ps2_host_tx #(
    parameter logic [7:0] PORT_TX        = 8'h0B,
    parameter int         INHIBIT_CYCLES = 10000,
    parameter int         TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       write_strobe,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    inout  wire        ps2c,
    inout  wire        ps2d,
    output logic       tx_idle,
    output logic       tx_busy,
    output logic       tx_done_tick,
    output logic       tx_error
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RTS   = 3'd1;
    localparam logic [2:0] START = 3'd2;
    localparam logic [2:0] DATA  = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;

    // A single counter serves as the inhibit timer in RTS and as the
    // device-clock watchdog afterwards, so it is sized for the larger limit.
    localparam int MAX_COUNT = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TW        = $clog2(MAX_COUNT + 1);
    localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]    state_q, state_d;
    logic [8:0]    shreg_q, shreg_d;
    logic [3:0]    bitCount_q, bitCount_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          error_q, error_d;
    logic          doneTick_q, doneTick_d;
    logic          idle_q;

    logic [1:0]    ps2cSync_q;
    logic [1:0]    ps2dSync_q;
    logic [7:0]    filtShift_q;
    logic          filtLevel_q;
    logic          filtLevelPrev_q;

    logic          filterClear;
    logic          fallEdge;
    logic          launch;

    // Bring both asynchronous PS/2 lines into the clk domain (released = 1).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps2cSync_q <= 2'b11;
            ps2dSync_q <= 2'b11;
        end else begin
            ps2cSync_q <= {ps2cSync_q[0], ps2c};
            ps2dSync_q <= {ps2dSync_q[0], ps2d};
        end
    end

    // Debounce the device clock: the level only changes after 8 equal samples;
    // forced high when entering START so our own RTS low is not seen as an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filtShift_q     <= 8'hFF;
            filtLevel_q     <= 1'b1;
            filtLevelPrev_q <= 1'b1;
        end else if (filterClear) begin
            filtShift_q     <= 8'hFF;
            filtLevel_q     <= 1'b1;
            filtLevelPrev_q <= 1'b1;
        end else begin
            filtShift_q     <= {filtShift_q[6:0], ps2cSync_q[1]};
            filtLevelPrev_q <= filtLevel_q;
            if (&filtShift_q) begin
                filtLevel_q <= 1'b1;
            end else if (~|filtShift_q) begin
                filtLevel_q <= 1'b0;
            end
        end
    end

    assign fallEdge = filtLevelPrev_q & ~filtLevel_q;
    assign launch   = write_strobe && (port_id == PORT_TX) && (state_q == IDLE);

    // Transmit sequencing: launch, inhibit, start bit, data/parity, stop and ACK,
    // with a watchdog on the gap between device clock edges.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bitCount_d  = bitCount_q;
        timer_d     = timer_q;
        error_d     = error_q;
        doneTick_d  = 1'b0;
        filterClear = 1'b0;
        case (state_q)
            IDLE: begin
                if (launch) begin
                    shreg_d    = {~^out_port, out_port};
                    error_d    = 1'b0;
                    timer_d    = '0;
                    bitCount_d = '0;
                    state_d    = RTS;
                end
            end
            RTS: begin
                if (timer_q == INHIBIT_LAST) begin
                    timer_d     = '0;
                    filterClear = 1'b1;
                    state_d     = START;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            START, DATA, STOP: begin
                if (fallEdge) begin
                    timer_d = '0;
                    if (state_q == START) begin
                        bitCount_d = '0;
                        state_d    = DATA;
                    end else if (state_q == DATA) begin
                        if (bitCount_q == 4'd8) begin
                            state_d = STOP;
                        end else begin
                            shreg_d    = {1'b0, shreg_q[8:1]};
                            bitCount_d = bitCount_q + 1'b1;
                        end
                    end else begin
                        if (ps2dSync_q[1]) begin
                            error_d = 1'b1;
                        end
                        doneTick_d = 1'b1;
                        state_d    = IDLE;
                    end
                end else if (timer_q == TIMEOUT_LAST) begin
                    timer_d    = '0;
                    error_d    = 1'b1;
                    doneTick_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Commit the transmitter state and the registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bitCount_q <= '0;
            timer_q    <= '0;
            error_q    <= 1'b0;
            doneTick_q <= 1'b0;
            idle_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bitCount_q <= bitCount_d;
            timer_q    <= timer_d;
            error_q    <= error_d;
            doneTick_q <= doneTick_d;
            idle_q     <= (state_d == IDLE);
        end
    end

    assign tx_idle      = idle_q;
    assign tx_busy      = ~idle_q;
    assign tx_done_tick = doneTick_q;
    assign tx_error     = error_q;

    assign ps2c = (state_q == RTS) ? 1'b0 : 1'bz;
    assign ps2d = ((state_q == START) || ((state_q == DATA) && !shreg_q[0])) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the
// host, and the sampled bits are compared against frames built from the byte.
module tb_ps2_host_tx;

    localparam int INH = 200;
    localparam int TO  = 1500;
    localparam int HP  = 40;

    logic       clk;
    logic       reset;
    logic       write_strobe;
    logic [7:0] port_id;
    logic [7:0] out_port;
    wire        ps2c;
    wire        ps2d;
    logic       tx_idle;
    logic       tx_busy;
    logic       tx_done_tick;
    logic       tx_error;

    logic       devClkLow;
    logic       devDatLow;

    int         checkCount;
    int         errorCount;
    int         doneCount;

    pullup(ps2c);
    pullup(ps2d);
    assign ps2c = devClkLow ? 1'b0 : 1'bz;
    assign ps2d = devDatLow ? 1'b0 : 1'bz;

    ps2_host_tx #(
        .PORT_TX        (8'h0B),
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .write_strobe (write_strobe),
        .port_id      (port_id),
        .out_port     (out_port),
        .ps2c         (ps2c),
        .ps2d         (ps2d),
        .tx_idle      (tx_idle),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick),
        .tx_error     (tx_error)
    );

    // Free-running 100 MHz system clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count completion pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (tx_done_tick === 1'b1) begin
            doneCount++;
        end
    end

    // Hard stop in case something hangs beyond every bounded wait.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // The frame a device should see for a byte: data LSB first, odd parity, stop.
    function automatic logic [9:0] expectedFrame(input logic [7:0] b);
        logic [9:0] f;
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i] = ((int'(b) / (2 ** i)) % 2) == 1;
            ones += ((int'(b) / (2 ** i)) % 2);
        end
        f[8] = (ones % 2) == 0;
        f[9] = 1'b1;
        return f;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] port, input logic [7:0] data);
        @(negedge clk);
        write_strobe = 1'b1;
        port_id      = port;
        out_port     = data;
        @(negedge clk);
        write_strobe = 1'b0;
    endtask

    // Behavioural device: nFalls clock pulses, samples data on each rising edge,
    // optionally ACKs on the 11th clock, injects glitches or a mid-frame write.
    task automatic deviceClock(input int nFalls, input bit ack, input bit glitch,
                               input bit midWrite, output logic [9:0] sampled);
        sampled = '0;
        for (int k = 1; k <= nFalls; k++) begin
            devClkLow = 1'b1;
            repeat (HP) @(negedge clk);
            devClkLow = 1'b0;
            if (k <= 10) begin
                sampled[k-1] = ps2d;
            end
            if (k == 10 && ack) begin
                devDatLow = 1'b1;
            end
            if (k == 11) begin
                devDatLow = 1'b0;
            end
            for (int c = 0; c < HP; c++) begin
                devClkLow = glitch && (k >= 2) && (k <= 8) && (c >= 15) && (c < 18);
                if (midWrite && k == 4 && c == 5) begin
                    write_strobe = 1'b1;
                    port_id      = 8'h0B;
                    out_port     = 8'h55;
                end else begin
                    write_strobe = 1'b0;
                end
                @(negedge clk);
            end
            devClkLow    = 1'b0;
            write_strobe = 1'b0;
        end
    endtask

    // Launch and check the RTS phase; returns once the host has released ps2c.
    task automatic launchAndInhibit(input logic [7:0] b);
        int lowCount;
        applyStimulus(8'h0B, b);
        checkOutput("launch_ps2c_low", ps2c, 0);
        checkOutput("busy_after_launch", tx_busy, 1);
        checkOutput("error_cleared", tx_error, 0);
        lowCount = 0;
        while (ps2c !== 1'b1 && lowCount < INH + 100) begin
            lowCount++;
            @(negedge clk);
        end
        checkOutput("rts_low_cycles", lowCount, INH);
        checkOutput("start_bit_low", ps2d, 0);
        repeat (30) @(negedge clk);
    endtask

    task automatic runTransfer(input logic [7:0] b, input bit ack, input bit glitch, input bit midWrite);
        logic [9:0] sampled;
        int startDone;
        int waitCount;
        startDone = doneCount;
        launchAndInhibit(b);
        deviceClock(11, ack, glitch, midWrite, sampled);
        waitCount = 0;
        while (tx_idle !== 1'b1 && waitCount < 200) begin
            waitCount++;
            @(negedge clk);
        end
        repeat (20) @(negedge clk);
        checkOutput("frame_bits", sampled, expectedFrame(b));
        checkOutput("done_once", doneCount - startDone, 1);
        checkOutput("error_flag", tx_error, !ack);
        checkOutput("back_idle", tx_idle, 1);
        checkOutput("lines_released", {ps2c, ps2d}, 2'b11);
    endtask

    initial begin
        logic [9:0] partial;
        int elapsed;
        int savedDone;
        checkCount   = 0;
        errorCount   = 0;
        doneCount    = 0;
        devClkLow    = 1'b0;
        devDatLow    = 1'b0;
        write_strobe = 1'b0;
        port_id      = 8'h00;
        out_port     = 8'h00;
        reset        = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset_status", {tx_idle, tx_busy, tx_done_tick, tx_error}, 4'b1000);
        checkOutput("reset_lines", {ps2c, ps2d}, 2'b11);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] ED with ACK");
        runTransfer(8'hED, 1'b1, 1'b0, 1'b0);

        $display("[TB] F4 with NACK");
        runTransfer(8'hF4, 1'b0, 1'b0, 1'b0);

        $display("[TB] 00 with write during data");
        runTransfer(8'h00, 1'b1, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        checkOutput("busy_write_ignored", tx_idle, 1);

        applyStimulus(8'h0A, 8'hAA);
        repeat (20) @(negedge clk);
        checkOutput("other_port_idle", tx_idle, 1);
        checkOutput("other_port_ps2c", ps2c, 1);

        $display("[TB] timeout after 4 device clocks");
        savedDone = doneCount;
        launchAndInhibit(8'h3C);
        deviceClock(4, 1'b0, 1'b0, 1'b0, partial);
        elapsed = 2 * HP;
        while (tx_done_tick !== 1'b1 && elapsed < TO + 200) begin
            elapsed++;
            @(negedge clk);
        end
        checkOutput("timeout_window", (elapsed >= TO && elapsed <= TO + 30), 1);
        checkOutput("timeout_error", tx_error, 1);
        checkOutput("timeout_lines", {ps2c, ps2d}, 2'b11);
        repeat (5) @(negedge clk);
        checkOutput("timeout_done_once", doneCount - savedDone, 1);
        runTransfer(8'hFF, 1'b1, 1'b0, 1'b0);

        $display("[TB] reset during rts");
        applyStimulus(8'h0B, 8'h12);
        repeat (50) @(negedge clk);
        savedDone = doneCount;
        reset = 1'b0;
        #1;
        checkOutput("rst_rts_lines", {ps2c, ps2d}, 2'b11);
        checkOutput("rst_rts_status", {tx_idle, tx_done_tick, tx_error}, 3'b100);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (50) @(negedge clk);
        checkOutput("rst_rts_no_done", doneCount - savedDone, 0);

        $display("[TB] reset during data");
        launchAndInhibit(8'h81);
        deviceClock(5, 1'b0, 1'b0, 1'b0, partial);
        checkOutput("rst_data_busy", tx_busy, 1);
        savedDone = doneCount;
        reset = 1'b0;
        #1;
        checkOutput("rst_data_lines", {ps2c, ps2d}, 2'b11);
        checkOutput("rst_data_status", {tx_idle, tx_done_tick, tx_error}, 3'b100);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (50) @(negedge clk);
        checkOutput("rst_data_no_done", doneCount - savedDone, 0);

        $display("[TB] ED with clock glitches");
        runTransfer(8'hED, 1'b1, 1'b1, 1'b0);

        $display("[TB] random transfers");
        for (int n = 0; n < 4; n++) begin
            logic [7:0] rb;
            bit rAck;
            bit rGlitch;
            rb      = 8'($urandom_range(0, 255));
            rAck    = 1'($urandom_range(0, 1));
            rGlitch = 1'($urandom_range(0, 1));
            runTransfer(rb, rAck, rGlitch, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
